// File: rtl/shift_unloader.sv
// shift_unloader: button/timer driven parallel-to-serial unloader for an 8-bit switch word
// Ports:
//   clock, reset (async active-low)
//   butt_load, butt_step       raw active-low push buttons
//   sw_data_raw, sw_msb_first_raw, sw_auto_raw   raw switches
//   serial_out                 bit currently presented
//   leds                       bits not yet sent (zero-filled)
//   busy, done                 status flags for SHIFT / DONE
//   bit_count                  bits fully sent in the current word
module shift_unloader #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         butt_load,
  input  logic                         butt_step,
  input  logic [WIDTH-1:0]             sw_data_raw,
  input  logic                         sw_msb_first_raw,
  input  logic                         sw_auto_raw,
  output logic                         serial_out,
  output logic [WIDTH-1:0]             leds,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int BW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        ld_s_q, st_s_q, msb_s_q, auto_s_q;
  logic [WIDTH-1:0]  data_s1_q, data_s2_q;
  logic              ld_prev_q, st_prev_q, ld_press_q, st_press_q;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              msb_q, msb_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     pre_q, pre_d;
  logic              auto_on, tick, step;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_s_q     <= 2'b11;
      st_s_q     <= 2'b11;
      ld_prev_q  <= 1'b1;
      st_prev_q  <= 1'b1;
      ld_press_q <= 1'b0;
      st_press_q <= 1'b0;
      msb_s_q    <= '0;
      auto_s_q   <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      state_q    <= IDLE;
      shreg_q    <= '0;
      msb_q      <= 1'b0;
      cnt_q      <= '0;
      pre_q      <= '0;
    end else begin
      ld_s_q     <= {ld_s_q[0], butt_load};
      st_s_q     <= {st_s_q[0], butt_step};
      ld_prev_q  <= ld_s_q[1];
      st_prev_q  <= st_s_q[1];
      ld_press_q <= ld_prev_q & ~ld_s_q[1];
      st_press_q <= st_prev_q & ~st_s_q[1];
      msb_s_q    <= {msb_s_q[0], sw_msb_first_raw};
      auto_s_q   <= {auto_s_q[0], sw_auto_raw};
      data_s1_q  <= sw_data_raw;
      data_s2_q  <= data_s1_q;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      msb_q      <= msb_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
    end
  end
  assign auto_on = (state_q == SHIFT) && auto_s_q[1];
  assign tick    = auto_on && (pre_q == CW'(TICK_DIV-1));
  assign step    = auto_s_q[1] ? tick : st_press_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    msb_d   = msb_q;
    cnt_d   = cnt_q;
    pre_d   = (auto_on && !tick) ? pre_q + CW'(1) : '0;
    if (ld_press_q) begin
      state_d = SHIFT;
      shreg_d = data_s2_q;
      msb_d   = msb_s_q[1];
      cnt_d   = '0;
      pre_d   = '0;
    end else if (state_q == SHIFT && step) begin
      shreg_d = msb_q ? shreg_q << 1 : shreg_q >> 1;
      cnt_d   = cnt_q + BW'(1);
      state_d = (cnt_q == BW'(WIDTH-1)) ? DONE : SHIFT;
    end
  end
  assign busy       = state_q == SHIFT;
  assign done       = state_q == DONE;
  assign serial_out = busy && (msb_q ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign leds       = busy ? shreg_q : '0;
  assign bit_count  = cnt_q;
endmodule

// File: tb/tb_shift_unloader.sv
// tb_shift_unloader: directed self-checking bench for shift_unloader (WIDTH=8, TICK_DIV=4)
module tb_shift_unloader;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       butt_load = 1'b1;
  logic       butt_step = 1'b1;
  logic [7:0] sw_data_raw = '0;
  logic       sw_msb_first_raw = 1'b0;
  logic       sw_auto_raw = 1'b0;
  logic       serial_out, busy, done;
  logic [7:0] leds;
  logic [3:0] bit_count;
  int         n_chk = 0;
  int         n_fail = 0;
  shift_unloader #(.WIDTH(8), .TICK_DIV(4)) dut (
    .clock(clock), .reset(reset), .butt_load(butt_load), .butt_step(butt_step),
    .sw_data_raw(sw_data_raw), .sw_msb_first_raw(sw_msb_first_raw), .sw_auto_raw(sw_auto_raw),
    .serial_out(serial_out), .leds(leds), .busy(busy), .done(done), .bit_count(bit_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press(input bit ld, input bit st);
    if (ld) butt_load = 1'b0;
    if (st) butt_step = 1'b0;
    repeat (5) @(negedge clock);
    butt_load = 1'b1;
    butt_step = 1'b1;
    repeat (4) @(negedge clock);
  endtask
  initial begin
    logic [7:0] w;
    int k;
    // 1: reset held with button activity
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      butt_load = i[0];
      butt_step = ~i[0];
    end
    butt_load = 1'b1;
    butt_step = 1'b1;
    @(negedge clock);
    check("rst_serial", serial_out, 0);
    check("rst_leds", leds, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", bit_count, 0);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("rel_busy", busy, 0);
    check("rel_leds", leds, 0);
    // 2: manual MSB-first A5
    w = 8'hA5;
    sw_data_raw = w;
    sw_msb_first_raw = 1'b1;
    press(1, 0);
    check("a5_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      check("a5_serial", serial_out, w[7-i]);
      check("a5_leds", leds, 8'(w << i));
      check("a5_cnt", bit_count, i);
      press(0, 1);
    end
    check("a5_done", done, 1);
    check("a5_busy_end", busy, 0);
    check("a5_cnt_end", bit_count, 8);
    check("a5_leds_end", leds, 0);
    check("a5_serial_end", serial_out, 0);
    // 3: auto LSB-first 01, one step per 4 clocks
    sw_data_raw = 8'h01;
    sw_msb_first_raw = 1'b0;
    sw_auto_raw = 1'b1;
    repeat (3) @(negedge clock);
    butt_load = 1'b0;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("auto_entry", busy, 1);
    for (int j = 0; j <= 32; j++) begin
      if (j > 0) @(negedge clock);
      if (j == 3) butt_load = 1'b1;
      check("auto_serial", serial_out, (j < 4) ? 1 : 0);
      check("auto_leds", leds, (j < 4) ? 8'h01 : 8'h00);
      check("auto_cnt", bit_count, j / 4);
      check("auto_done", done, (j == 32) ? 1 : 0);
    end
    sw_auto_raw = 1'b0;
    repeat (4) @(negedge clock);
    // 4: abort mid-word by reload
    sw_data_raw = 8'hF0;
    sw_msb_first_raw = 1'b1;
    press(1, 0);
    check("f0_leds", leds, 8'hF0);
    check("f0_serial", serial_out, 1);
    repeat (3) press(0, 1);
    check("f0_cnt3", bit_count, 3);
    check("f0_leds3", leds, 8'h80);
    sw_data_raw = 8'h0F;
    press(1, 0);
    check("0f_cnt", bit_count, 0);
    check("0f_leds", leds, 8'h0F);
    check("0f_serial", serial_out, 0);
    check("0f_busy", busy, 1);
    // 5: simultaneous load and step, step in DONE
    press(0, 1);
    check("0f_cnt1", bit_count, 1);
    check("0f_leds1", leds, 8'h1E);
    sw_data_raw = 8'h3C;
    press(1, 1);
    check("both_cnt", bit_count, 0);
    check("both_leds", leds, 8'h3C);
    repeat (8) press(0, 1);
    check("3c_done", done, 1);
    press(0, 1);
    check("donestep_done", done, 1);
    check("donestep_cnt", bit_count, 8);
    check("donestep_leds", leds, 0);
    // 6: async reset mid-word, step in IDLE, held step
    sw_data_raw = 8'hFF;
    sw_msb_first_raw = 1'b0;
    press(1, 0);
    repeat (5) press(0, 1);
    check("ff_cnt5", bit_count, 5);
    check("ff_leds5", leds, 8'h07);
    check("ff_serial5", serial_out, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_leds", leds, 0);
    check("arst_cnt", bit_count, 0);
    check("arst_serial", serial_out, 0);
    check("arst_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("post_busy", busy, 0);
    press(0, 1);
    check("idlestep_busy", busy, 0);
    check("idlestep_cnt", bit_count, 0);
    press(1, 0);
    check("ff2_leds", leds, 8'hFF);
    butt_step = 1'b0;
    repeat (100) @(negedge clock);
    butt_step = 1'b1;
    repeat (4) @(negedge clock);
    check("hold_cnt", bit_count, 1);
    check("hold_leds", leds, 8'h7F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
